// File: rtl/result_stream_arbiter_pkg.sv
// result_arb_pkg: shared types and constants for result_stream_arbiter.
//   - arb_state_e : arbiter FSM state encoding (TAG exists only when
//                   RESULT_ARB_TAG_EN is defined)
//   - TAG_PREFIX  : upper bits of the per-requester tag word
//   - MAX_REQ     : largest supported requester count
//   - tag_word()  : builds the tag word for a grant index
package result_arb_pkg;

  localparam int          MAX_REQ    = 8;
  localparam int          MAX_IDX_W  = $clog2(MAX_REQ);
  localparam logic [31:0] TAG_PREFIX = 32'hC0DE_0000;

`ifdef RESULT_ARB_TAG_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    TAG    = 2'd2,
    SEND   = 2'd3
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SEND   = 2'd3
  } arb_state_e;
`endif

  // Tag word announcing which requester the following data word came from.
  function automatic logic [31:0] tag_word(input logic [MAX_IDX_W-1:0] g);
    return TAG_PREFIX | {{(32 - MAX_IDX_W){1'b0}}, g};
  endfunction

endpackage

// File: rtl/result_stream_arbiter_if.sv
// result_stream_arbiter_if: requester-side and sink-side stb/ack bundle.
//   in_data  : NUM_REQ packed 32-bit words, requester i at [32*i+31:32*i]
//   in_stb   : per-requester strobe, held until acked
//   in_ack   : per-requester acknowledge (one-hot or zero)
//   out_data : word to the sink
//   out_stb  : output strobe, held until out_ack
//   out_ack  : sink acknowledge
// Modports: slave = arbiter view, master = surrounding environment view.
interface result_stream_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [32*NUM_REQ-1:0] in_data;
  logic [NUM_REQ-1:0]    in_stb;
  logic [NUM_REQ-1:0]    in_ack;
  logic [31:0]           out_data;
  logic                  out_stb;
  logic                  out_ack;

  modport slave (
    input  in_data, in_stb, out_ack,
    output in_ack, out_data, out_stb
  );

  modport master (
    output in_data, in_stb, out_ack,
    input  in_ack, out_data, out_stb
  );

endinterface

// File: rtl/result_stream_arbiter_rr_picker.sv
// rr_picker: combinational rotating-priority search.
//   req    : request vector, one bit per requester
//   rr_ptr : index holding highest priority
//   any    : at least one request is pending
//   grant  : first requesting index found from rr_ptr upward, wrapping
//            modulo NUM_REQ (valid only when any is high)
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               any,
  output logic [IDX_W-1:0]   grant
);

  // Index that sits 'offset' places after 'base', wrapped for any NUM_REQ.
  function automatic logic [IDX_W-1:0] slot(input logic [IDX_W-1:0] base,
                                            input int offset);
    int sum;
    sum = int'(base) + offset;
    sum = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
    return sum[IDX_W-1:0];
  endfunction

  // Walk from the lowest-priority slot back to rr_ptr so the closest
  // pending requester to rr_ptr is the last (winning) assignment.
  always_comb begin
    any   = 1'b0;
    grant = {IDX_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      any   = any | req[slot(rr_ptr, k)];
      grant = req[slot(rr_ptr, k)] ? slot(rr_ptr, k) : grant;
    end
  end

endmodule

// File: rtl/result_stream_arbiter.sv
// result_stream_arbiter: shares one 32-bit stb/ack sink among NUM_REQ
// producing streams with rotating priority. One word is accepted from the
// granted requester, forwarded to the sink, then priority rotates past it.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset
//   bus        : result_stream_arbiter_if.slave (requester and sink handshakes)
//   busy       : high whenever the FSM is outside IDLE
//   xfer_count : data words delivered to the sink, wraps modulo 2^32
// Build option: define RESULT_ARB_TAG_EN to precede every data word with the
// tag word TAG_PREFIX | grant index.
module result_stream_arbiter
  import result_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  result_stream_arbiter_if.slave   bus,
  output logic                     busy,
  output logic [31:0]              xfer_count
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e           state_r, next_state_s;
  logic [IDX_W-1:0]     grant_r, next_grant_s;
  logic [IDX_W-1:0]     rr_ptr_r, next_rr_ptr_s;
  logic [NUM_REQ-1:0]   in_ack_r, next_in_ack_s;
  logic                 out_stb_r, next_out_stb_s;
  logic [31:0]          out_data_r, next_out_data_s;
  logic                 busy_r, next_busy_s;
  logic [31:0]          xfer_count_r, next_xfer_count_s;
`ifdef RESULT_ARB_TAG_EN
  logic [31:0]          buf_r, next_buf_s;
`endif

  logic                 pick_any_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic [31:0]          sel_data_s;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (bus.in_stb),
    .rr_ptr (rr_ptr_r),
    .any    (pick_any_s),
    .grant  (pick_idx_s)
  );

  assign sel_data_s = bus.in_data[32*grant_r +: 32];

  // Next-state and next-output decode; every register has a hold default.
  always_comb begin
    next_state_s      = state_r;
    next_grant_s      = grant_r;
    next_rr_ptr_s     = rr_ptr_r;
    next_in_ack_s     = {NUM_REQ{1'b0}};
    next_out_stb_s    = 1'b0;
    next_out_data_s   = out_data_r;
    next_xfer_count_s = xfer_count_r;
`ifdef RESULT_ARB_TAG_EN
    next_buf_s        = buf_r;
`endif
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          next_state_s  = ACCEPT;
          next_grant_s  = pick_idx_s;
          next_in_ack_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
        end else begin
          next_state_s  = IDLE;
        end
      end
      ACCEPT: begin
        // in_ack[g] is high this cycle, so a held strobe completes the
        // transfer now; a withdrawn strobe abandons the grant untouched.
        if (bus.in_stb[grant_r]) begin
          next_out_stb_s  = 1'b1;
`ifdef RESULT_ARB_TAG_EN
          next_buf_s      = sel_data_s;
          next_out_data_s = tag_word(MAX_IDX_W'(grant_r));
          next_state_s    = TAG;
`else
          next_out_data_s = sel_data_s;
          next_state_s    = SEND;
`endif
        end else begin
          next_state_s    = IDLE;
        end
      end
`ifdef RESULT_ARB_TAG_EN
      TAG: begin
        // out_stb stays high straight through into the data word.
        next_out_stb_s = 1'b1;
        if (bus.out_ack) begin
          next_out_data_s = buf_r;
          next_state_s    = SEND;
        end else begin
          next_state_s    = TAG;
        end
      end
`endif
      SEND: begin
        if (bus.out_ack) begin
          next_out_stb_s    = 1'b0;
          next_state_s      = IDLE;
          next_rr_ptr_s     = (grant_r == LAST_IDX) ? {IDX_W{1'b0}}
                                                    : grant_r + IDX_W'(1);
          next_xfer_count_s = xfer_count_r + 32'd1;
        end else begin
          next_out_stb_s    = 1'b1;
          next_state_s      = SEND;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
    next_busy_s = (next_state_s != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= {IDX_W{1'b0}};
      rr_ptr_r     <= {IDX_W{1'b0}};
      in_ack_r     <= {NUM_REQ{1'b0}};
      out_stb_r    <= 1'b0;
      out_data_r   <= 32'd0;
      busy_r       <= 1'b0;
      xfer_count_r <= 32'd0;
`ifdef RESULT_ARB_TAG_EN
      buf_r        <= 32'd0;
`endif
    end else begin
      state_r      <= next_state_s;
      grant_r      <= next_grant_s;
      rr_ptr_r     <= next_rr_ptr_s;
      in_ack_r     <= next_in_ack_s;
      out_stb_r    <= next_out_stb_s;
      out_data_r   <= next_out_data_s;
      busy_r       <= next_busy_s;
      xfer_count_r <= next_xfer_count_s;
`ifdef RESULT_ARB_TAG_EN
      buf_r        <= next_buf_s;
`endif
    end
  end

  assign bus.in_ack   = in_ack_r;
  assign bus.out_stb  = out_stb_r;
  assign bus.out_data = out_data_r;
  assign busy         = busy_r;
  assign xfer_count   = xfer_count_r;

endmodule

// File: tb/tb_result_stream_arbiter.sv
// tb_result_stream_arbiter: directed bench with an output scoreboard for a
// 4-requester and a 3-requester arbiter. Expected sink words are queued when
// requests are issued; monitors pop and compare on every sink transfer.
module tb_result_stream_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_stream_arbiter_if #(.NUM_REQ(4)) bus4 ();
  result_stream_arbiter_if #(.NUM_REQ(3)) bus3 ();

  logic         busy4, busy3;
  logic [31:0]  xc4, xc3;
  logic [3:0]   stb4;
  logic [127:0] data4;
  logic         ack4;
  logic [2:0]   stb3;
  logic [95:0]  data3;
  logic         ack3;

  assign bus4.in_stb  = stb4;
  assign bus4.in_data = data4;
  assign bus4.out_ack = ack4;
  assign bus3.in_stb  = stb3;
  assign bus3.in_data = data3;
  assign bus3.out_ack = ack3;

  result_stream_arbiter #(.NUM_REQ(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .busy(busy4), .xfer_count(xc4)
  );
  result_stream_arbiter #(.NUM_REQ(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .busy(busy3), .xfer_count(xc3)
  );

  int checks;
  int errors;
  logic [31:0] q4[$];
  logic [31:0] q3[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push4(input int g, input logic [31:0] d);
`ifdef RESULT_ARB_TAG_EN
    q4.push_back(32'hC0DE_0000 | 32'(g));
`endif
    q4.push_back(d);
  endtask

  task automatic push3(input int g, input logic [31:0] d);
`ifdef RESULT_ARB_TAG_EN
    q3.push_back(32'hC0DE_0000 | 32'(g));
`endif
    q3.push_back(d);
  endtask

  // One clock: requesters drop their strobe after an acked edge.
  task automatic tick();
    logic [3:0] a4;
    logic [2:0] a3;
    @(negedge clk);
    a4 = bus4.in_ack & stb4;
    a3 = bus3.in_ack & stb3;
    @(posedge clk);
    #1;
    stb4 = stb4 & ~a4;
    stb3 = stb3 & ~a3;
  endtask

  task automatic wait_idle(input bit use3, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!use3 && stb4 == 4'd0 && !busy4 && !bus4.out_stb && q4.size() == 0) begin
        done = 1'b1;
        break;
      end
      if (use3 && stb3 == 3'd0 && !busy3 && !bus3.out_stb && q3.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, "_drained"}, 32'(done), 32'd1);
  endtask

  // Scoreboard monitor for the 4-requester instance.
  always @(negedge clk) begin
    if (!rst && bus4.out_stb && bus4.out_ack) begin
      if (q4.size() == 0) begin
        chk("out4_unexpected_word", bus4.out_data, 32'hFFFF_FFFF ^ bus4.out_data);
      end else begin
        chk("out4_word", bus4.out_data, q4.pop_front());
      end
    end
  end

  // Scoreboard monitor for the 3-requester instance.
  always @(negedge clk) begin
    if (!rst && bus3.out_stb && bus3.out_ack) begin
      if (q3.size() == 0) begin
        chk("out3_unexpected_word", bus3.out_data, 32'hFFFF_FFFF ^ bus3.out_data);
      end else begin
        chk("out3_word", bus3.out_data, q3.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    bit          seen;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    stb4 = 4'd0; data4 = 128'd0; ack4 = 1'b1;
    stb3 = 3'd0; data3 = 96'd0;  ack3 = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_in_ack",   32'(bus4.in_ack), 32'd0);
    chk("rst_out_stb",  32'(bus4.out_stb), 32'd0);
    chk("rst_out_data", bus4.out_data, 32'd0);
    chk("rst_busy",     32'(busy4), 32'd0);
    chk("rst_xfer",     xc4, 32'd0);
    rst = 1'b0;
    tick();

    // Single requester 0, latency and count
    data4[31:0] = 32'h3F80_0000;
    stb4[0]     = 1'b1;
    push4(0, 32'h3F80_0000);
    tick();
    chk("lat_in_ack",   32'(bus4.in_ack), 32'd1);
    chk("lat_out_stb0", 32'(bus4.out_stb), 32'd0);
    chk("lat_busy",     32'(busy4), 32'd1);
    tick();
    chk("lat_out_stb1", 32'(bus4.out_stb), 32'd1);
    wait_idle(1'b0, "single");
    chk("single_xfer", xc4, 32'd1);

    // rr_ptr is now 1: requesters 0 and 1 together serve 1 first
    data4[31:0]  = 32'hA000_0000;
    data4[63:32] = 32'hA000_0001;
    stb4 = 4'b0011;
    push4(1, 32'hA000_0001);
    push4(0, 32'hA000_0000);
    wait_idle(1'b0, "rotate");
    chk("rotate_xfer", xc4, 32'd3);

    // Four requesters pending from reset, twice
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      data4 = {32'd13, 32'd12, 32'd11, 32'd10};
      stb4  = 4'hF;
      for (int g = 0; g < 4; g++) push4(g, 32'(10 + g));
      wait_idle(1'b0, "all4");
    end
    chk("all4_xfer", xc4, 32'd8);

    // Sink stall for 20 cycles with another request pending
    ack4 = 1'b0;
    data4[63:32] = 32'hDEAD_BEEF;
    stb4[1] = 1'b1;
    push4(1, 32'hDEAD_BEEF);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus4.out_stb) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stall_out_stb_seen", 32'(seen), 32'd1);
    held = bus4.out_data;
    data4[95:64] = 32'h0000_0022;
    stb4[2] = 1'b1;
    push4(2, 32'h0000_0022);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_out_stb",  32'(bus4.out_stb), 32'd1);
      chk("stall_out_data", bus4.out_data, held);
      chk("stall_in_ack",   32'(bus4.in_ack), 32'd0);
    end
    ack4 = 1'b1;
    wait_idle(1'b0, "stall");
    chk("stall_xfer", xc4, 32'd10);

    // Reset while the data word waits in SEND
    data4[127:96] = 32'hBAD0_BAD0;
    stb4[3] = 1'b1;
`ifdef RESULT_ARB_TAG_EN
    q4.push_back(32'hC0DE_0003);
    ack4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (q4.size() == 0) break;
    end
    ack4 = 1'b0;
`else
    ack4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus4.out_stb) break;
    end
`endif
    repeat (3) tick();
    chk("send_hold_out_stb", 32'(bus4.out_stb), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_in_ack",   32'(bus4.in_ack), 32'd0);
    chk("mid_rst_out_stb",  32'(bus4.out_stb), 32'd0);
    chk("mid_rst_out_data", bus4.out_data, 32'd0);
    chk("mid_rst_busy",     32'(busy4), 32'd0);
    chk("mid_rst_xfer",     xc4, 32'd0);
    rst  = 1'b0;
    ack4 = 1'b1;
    repeat (5) tick();
    chk("dropped_out_stb", 32'(bus4.out_stb), 32'd0);
    chk("dropped_queue",   32'(q4.size()), 32'd0);

    // Requester 2 single word: tag then data when tags are built in
    data4[95:64] = 32'h4049_0FDB;
    stb4[2] = 1'b1;
    push4(2, 32'h4049_0FDB);
    wait_idle(1'b0, "tag");
    chk("tag_xfer", xc4, 32'd1);

    // NUM_REQ=3: grant 2 wraps rr_ptr to 0, then 0 before 1
    data3[95:64] = 32'h0000_0200;
    stb3[2] = 1'b1;
    push3(2, 32'h0000_0200);
    wait_idle(1'b1, "wrap_first");
    data3[31:0]  = 32'h0000_0100;
    data3[63:32] = 32'h0000_0101;
    stb3 = 3'b011;
    push3(0, 32'h0000_0100);
    push3(1, 32'h0000_0101);
    wait_idle(1'b1, "wrap_order");
    chk("wrap_xfer", xc3, 32'd3);

    chk("final_q4_empty", 32'(q4.size()), 32'd0);
    chk("final_q3_empty", 32'(q3.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_stream_arbiter.md
# result_stream_arbiter

Shares a single 32-bit stb/ack result sink (the testbench file writer) among up to eight producing streams, e.g. several floating-point units under test. Rotating-priority arbitration picks one pending requester, accepts one word from it, forwards that word to the sink, then rotates priority. It sits between the units' result ports and the file writer's `input_a` port, so the response file holds every unit's results in arbitration order.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters. Legal range 2..8. `IDX_W = $clog2(NUM_REQ)`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. Synchronous, active-high. Clock is `clk`.
- `in_data`  in  32*NUM_REQ  requester words. Requester i occupies bits [32*i+31 : 32*i].
- `in_stb`  in  NUM_REQ  per-requester strobe. A requester holds it high until acked.
- `in_ack`  out  NUM_REQ  per-requester acknowledge. At most one bit is high at a time.
- `out_data`  out  32  word to the sink.
- `out_stb`  out  1  output strobe. Held high until the sink acks.
- `out_ack`  in  1  sink acknowledge. Connects to the file writer's `input_a_ack`.
- `busy`  out  1  high in any state other than IDLE.
- `xfer_count`  out  32  number of data words delivered to the sink. Wraps modulo 2^32.

## Operation
- Transfer rule on both sides: a word moves on a rising edge where stb and ack are both 1.
- `rr_ptr` (IDX_W bits, reset 0) marks the highest-priority requester.
- Grant: the first i with `in_stb[i]=1`, searching rr_ptr, rr_ptr+1, … and wrapping modulo NUM_REQ.
- FSM states: IDLE, ACCEPT, TAG (only when the macro is defined), SEND.
  - IDLE: if any `in_stb` is high, register the grant index `g` and go to ACCEPT. Otherwise stay in IDLE.
  - ACCEPT: drive `in_ack[g]=1`.
    - If `in_stb[g]=1`: capture `in_data[g]` into `buf`, drop the ack next cycle, go to TAG if compiled in, else SEND.
    - If `in_stb[g]=0` (protocol violation / withdrawal): return to IDLE. No capture, rr_ptr unchanged.
  - TAG: `out_stb=1`, `out_data = TAG_PREFIX | g`. On `out_ack`, go to SEND.
  - SEND: `out_stb=1`, `out_data=buf`. On `out_ack`:
    - go to IDLE;
    - `rr_ptr <= (g+1) mod NUM_REQ` (non-power-of-two NUM_REQ wraps explicitly);
    - `xfer_count` increments. Tag words are not counted.
- `out_data` holds its last value while `out_stb` is low. Only `out_stb` qualifies it.
- Requester strobes arriving during ACCEPT, TAG or SEND are simply held pending. None is lost, because acks are withheld.

## Timing
- Reset values: `in_ack=0`, `out_stb=0`, `out_data=0`, `busy=0`, `xfer_count=0`, rr_ptr=0, state IDLE.
- A reset asserted mid-transfer discards `buf`. A requester already acked has lost that word; this is accepted.
- All outputs are registered. There is no combinational path from input to output.
- Latency, measured from `in_stb` first sampled high in IDLE at edge E:
  - `in_ack` is high in the cycle after E.
  - `out_stb` rises 2 cycles after E.
  - With TAG compiled in, the tag word appears first and the data word follows the tag's acceptance by at least 1 cycle.
- Throughput with the sink acking immediately: 3 cycles per word, or 4 with TAG.
- `out_ack` stuck low: stays in SEND/TAG indefinitely with `out_stb` held high.
- `out_ack` high while `out_stb` is low is ignored.
- Simultaneous events:
  - All requesters pending: the grant order is strictly rr_ptr, rr_ptr+1, …, so no requester waits more than NUM_REQ-1 transfers.
  - A single persistent requester is regranted every transfer.

## Configuration
- `RESULT_ARB_TAG_EN`.
  - Defined: the TAG state is compiled in. Every data word is preceded on the output by a tag word `32'hC0DE_0000 | g`, so the response file can be demultiplexed per unit.
  - Undefined: no TAG state. The output carries data words only, and the FSM has three states.
  - `xfer_count` semantics are identical in both builds.

## Structure
- Package `result_arb_pkg` contains:
  - the FSM state enum (IDLE, ACCEPT, TAG, SEND);
  - `TAG_PREFIX = 32'hC0DE_0000`;
  - `MAX_REQ = 8`.
- Sub-module `rr_picker`: combinational rotating-priority search. Inputs are the request vector and rr_ptr; outputs are `any` and the grant index. It is instantiated once.

## Test plan
- Single requester 0 sends `32'h3F800000` with the sink always acking -> `out_data=32'h3F800000`, `out_stb` rises 2 cycles after `in_stb`, `xfer_count=1`.
- Four requesters pending simultaneously from reset with words 10, 11, 12, 13 -> output order 10, 11, 12, 13. Then re-request all with rr_ptr=0 -> the same order repeats. `xfer_count=8`.
- Sink withholds `out_ack` for 20 cycles -> `out_stb` and `out_data` stay stable for all 20 cycles, and no `in_ack` is asserted in that time.
- `rst` asserted during SEND -> next cycle all outputs are at reset values, and the dropped word never appears on `out_data`.
- With `RESULT_ARB_TAG_EN`, requester 2 sends `32'h40490FDB` -> output `32'hC0DE0002` then `32'h40490FDB`, `xfer_count=1`. Without the macro only `32'h40490FDB` appears.
- NUM_REQ=3, requester 2 granted -> next rr_ptr is 0 (wrap), and a pending requester 0 is served before requester 1.
